id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 12 +
 rtl/id_ex_stage_entry.sv | 58 +++++
 rtl/id_ex_stage.sv | 115 +++++++++++
 tb/tb_id_ex_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths and occupancy-state encoding for the decode/execute boundary stage.
package id_ex_stage_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_AW = 4;
  localparam int OPC_W      = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;
endpackage

// File: rtl/id_ex_stage_entry.sv
// One held instruction: captures with write-before-read bypass, then refreshes its
// operands from the register-file write port while it is held.
module id_ex_entry
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              held,
  input  logic [REG_AW-1:0] SrcReg1,
  input  logic [REG_AW-1:0] SrcReg2,
  input  logic [DATA_W-1:0] SrcData1,
  input  logic [DATA_W-1:0] SrcData2,
  input  logic [OPC_W-1:0]  Opcode,
  input  logic [DATA_W-1:0] Imm,
  input  logic [REG_AW-1:0] DstReg,
  input  logic              WriteReg,
  input  logic [REG_AW-1:0] wb_DstReg,
  input  logic              wb_WriteReg,
  input  logic [DATA_W-1:0] wb_DstData,
  output logic [DATA_W-1:0] entA,
  output logic [DATA_W-1:0] entB,
  output logic [DATA_W-1:0] entImm,
  output logic [OPC_W-1:0]  entOpcode,
  output logic [REG_AW-1:0] entDstReg,
  output logic              entWriteReg,
  output logic [REG_AW-1:0] entSrcReg1,
  output logic [REG_AW-1:0] entSrcReg2
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entA        <= '0;
      entB        <= '0;
      entImm      <= '0;
      entOpcode   <= '0;
      entDstReg   <= '0;
      entWriteReg <= 1'b0;
      entSrcReg1  <= '0;
      entSrcReg2  <= '0;
    end else if (load) begin
      // Register 0 is an ordinary register here, so it bypasses like any other.
      entA        <= (wb_WriteReg && wb_DstReg == SrcReg1) ? wb_DstData : SrcData1;
      entB        <= (wb_WriteReg && wb_DstReg == SrcReg2) ? wb_DstData : SrcData2;
      entImm      <= Imm;
      entOpcode   <= Opcode;
      entDstReg   <= DstReg;
      entWriteReg <= WriteReg;
      entSrcReg1  <= SrcReg1;
      entSrcReg2  <= SrcReg2;
    end else if (held && wb_WriteReg) begin
      if (entSrcReg1 == wb_DstReg) entA <= wb_DstData;
      if (entSrcReg2 == wb_DstReg) entB <= wb_DstData;
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// Two-entry ID/EX skid buffer with operand bypass on capture and refresh while held.
// Valid/ready: a side transfers on a rising edge where its valid and ready are both high.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] SrcReg1,
  input  logic [REG_AW-1:0] SrcReg2,
  input  logic [DATA_W-1:0] SrcData1,
  input  logic [DATA_W-1:0] SrcData2,
  input  logic [OPC_W-1:0]  Opcode,
  input  logic [DATA_W-1:0] Imm,
  input  logic [REG_AW-1:0] DstReg,
  input  logic              WriteReg,
  input  logic [REG_AW-1:0] wb_DstReg,
  input  logic              wb_WriteReg,
  input  logic [DATA_W-1:0] wb_DstData,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  output logic [DATA_W-1:0] out_Imm,
  output logic [OPC_W-1:0]  out_Opcode,
  output logic [REG_AW-1:0] out_DstReg,
  output logic              out_WriteReg,
  output logic [REG_AW-1:0] out_SrcReg1,
  output logic [REG_AW-1:0] out_SrcReg2,
  output occ_state_t        dbgState
);
  occ_state_t  state, nextState;
  logic        rdPtr, nextRdPtr, wrSlot, inXfer, outXfer;
  logic [1:0]  load, held;

  logic [DATA_W-1:0] entA [2];
  logic [DATA_W-1:0] entB [2];
  logic [DATA_W-1:0] entImm [2];
  logic [OPC_W-1:0]  entOpcode [2];
  logic [REG_AW-1:0] entDstReg [2];
  logic              entWriteReg [2];
  logic [REG_AW-1:0] entSrcReg1 [2];
  logic [REG_AW-1:0] entSrcReg2 [2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      rdPtr    <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= nextState;
      rdPtr    <= nextRdPtr;
      in_ready <= (nextState != ST_TWO);
    end
  end

  // The head pointer stays put when the buffer drains, so the outputs keep the last head.
  always_comb begin
    nextState = state;
    nextRdPtr = rdPtr;
    inXfer    = in_valid && in_ready;
    outXfer   = out_valid && out_ready;
    wrSlot    = (state == ST_EMPTY) ? rdPtr : ~rdPtr;
    load      = 2'b00;
    held      = 2'b00;
    if (state != ST_EMPTY) held[rdPtr] = 1'b1;
    if (state == ST_TWO)   held[~rdPtr] = 1'b1;
    if (flush) begin
      nextState = ST_EMPTY;
    end else begin
      if (inXfer) load[wrSlot] = 1'b1;
      case (state)
        ST_EMPTY: if (inXfer) nextState = ST_ONE;
        ST_ONE: begin
          if (inXfer && !outXfer) nextState = ST_TWO;
          else if (!inXfer && outXfer) nextState = ST_EMPTY;
          if (inXfer && outXfer) nextRdPtr = ~rdPtr;
        end
        ST_TWO: if (outXfer) begin
          nextState = ST_ONE;
          nextRdPtr = ~rdPtr;
        end
        default: nextState = ST_EMPTY;
      endcase
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_entry
    id_ex_entry #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_entry (
      .clk(clk), .rst(rst), .load(load[g]), .held(held[g]),
      .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .SrcData1(SrcData1), .SrcData2(SrcData2),
      .Opcode(Opcode), .Imm(Imm), .DstReg(DstReg), .WriteReg(WriteReg),
      .wb_DstReg(wb_DstReg), .wb_WriteReg(wb_WriteReg), .wb_DstData(wb_DstData),
      .entA(entA[g]), .entB(entB[g]), .entImm(entImm[g]), .entOpcode(entOpcode[g]),
      .entDstReg(entDstReg[g]), .entWriteReg(entWriteReg[g]),
      .entSrcReg1(entSrcReg1[g]), .entSrcReg2(entSrcReg2[g])
    );
  end

  assign out_valid    = (state != ST_EMPTY);
  assign out_A        = entA[rdPtr];
  assign out_B        = entB[rdPtr];
  assign out_Imm      = entImm[rdPtr];
  assign out_Opcode   = entOpcode[rdPtr];
  assign out_DstReg   = entDstReg[rdPtr];
  assign out_WriteReg = entWriteReg[rdPtr];
  assign out_SrcReg1  = entSrcReg1[rdPtr];
  assign out_SrcReg2  = entSrcReg2[rdPtr];
  assign dbgState     = state;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, bypass, backpressure, refresh, flush, async reset.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  SrcReg1 = '0, SrcReg2 = '0, DstReg = '0, Opcode = '0;
  logic [15:0] SrcData1 = '0, SrcData2 = '0, Imm = '0;
  logic        WriteReg = 1'b0;
  logic [3:0]  wb_DstReg = '0;
  logic        wb_WriteReg = 1'b0;
  logic [15:0] wb_DstData = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out_A, out_B, out_Imm;
  logic [3:0]  out_Opcode, out_DstReg, out_SrcReg1, out_SrcReg2;
  logic        out_WriteReg;
  occ_state_t  dbgState;

  int tests = 0;
  int failed = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .SrcData1(SrcData1), .SrcData2(SrcData2),
    .Opcode(Opcode), .Imm(Imm), .DstReg(DstReg), .WriteReg(WriteReg),
    .wb_DstReg(wb_DstReg), .wb_WriteReg(wb_WriteReg), .wb_DstData(wb_DstData),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_A(out_A), .out_B(out_B), .out_Imm(out_Imm), .out_Opcode(out_Opcode),
    .out_DstReg(out_DstReg), .out_WriteReg(out_WriteReg),
    .out_SrcReg1(out_SrcReg1), .out_SrcReg2(out_SrcReg2), .dbgState(dbgState)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] s1, input logic [15:0] d1,
                           input logic [3:0] s2, input logic [15:0] d2,
                           input logic [3:0] opc, input logic [15:0] imm,
                           input logic [3:0] dst, input logic we);
    SrcReg1 = s1; SrcData1 = d1; SrcReg2 = s2; SrcData2 = d2;
    Opcode = opc; Imm = imm; DstReg = dst; WriteReg = we;
  endtask

  task automatic set_wb(input logic we, input logic [3:0] dst, input logic [15:0] data);
    wb_WriteReg = we; wb_DstReg = dst; wb_DstData = data;
  endtask

  task automatic push(input logic [15:0] d1);
    set_instr(4'd1, d1, 4'd2, 16'h0000, 4'd1, 16'h0000, 4'd3, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    tests++; if (out_A !== 16'h0000) begin failed++; $display("FAIL rst_out_A: got %h exp 0000", out_A); end
    tests++; if (dbgState !== ST_EMPTY) begin failed++; $display("FAIL rst_state: got %0d exp 0", dbgState); end
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_capture();
    set_instr(4'd3, 16'h1234, 4'd2, 16'h0042, 4'd5, 16'hFFF0, 4'd9, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL cap_valid: got %b exp 1", out_valid); end
    tests++; if (out_A !== 16'h1234) begin failed++; $display("FAIL cap_A: got %h exp 1234", out_A); end
    tests++; if (out_B !== 16'h0042) begin failed++; $display("FAIL cap_B: got %h exp 0042", out_B); end
    tests++; if (out_Opcode !== 4'd5 || out_Imm !== 16'hFFF0) begin failed++; $display("FAIL cap_opc_imm: got %h/%h exp 5/fff0", out_Opcode, out_Imm); end
    tests++; if (out_DstReg !== 4'd9 || out_WriteReg !== 1'b1) begin failed++; $display("FAIL cap_dst: got %h/%b exp 9/1", out_DstReg, out_WriteReg); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failed++; $display("FAIL cap_drain: got valid %b ready %b exp 0/1", out_valid, in_ready); end
    tests++; if (out_A !== 16'h1234) begin failed++; $display("FAIL cap_hold_A: got %h exp 1234", out_A); end
  endtask

  task automatic test_bypass();
    set_instr(4'd4, 16'h1111, 4'd5, 16'h0000, 4'd2, 16'h0005, 4'd5, 1'b1);
    set_wb(1'b1, 4'd5, 16'hBEEF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    set_wb(1'b0, 4'd0, 16'h0000);
    tests++; if (out_B !== 16'hBEEF) begin failed++; $display("FAIL byp_B: got %h exp beef", out_B); end
    tests++; if (out_A !== 16'h1111) begin failed++; $display("FAIL byp_A_nomatch: got %h exp 1111", out_A); end
    tests++; if (out_Imm !== 16'h0005 || out_DstReg !== 4'd5) begin failed++; $display("FAIL byp_untouched: got %h/%h exp 0005/5", out_Imm, out_DstReg); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    set_instr(4'd0, 16'h7777, 4'd6, 16'h0066, 4'd1, 16'h0000, 4'd0, 1'b1);
    set_wb(1'b1, 4'd0, 16'h00AA);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    set_wb(1'b0, 4'd0, 16'h0000);
    tests++; if (out_A !== 16'h00AA) begin failed++; $display("FAIL byp_r0_A: got %h exp 00aa", out_A); end
    tests++; if (out_B !== 16'h0066) begin failed++; $display("FAIL byp_r0_B: got %h exp 0066", out_B); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    set_instr(4'd1, 16'h0A00, 4'd2, 16'h0000, 4'd1, 16'h0000, 4'd3, 1'b1);
    in_valid = 1'b1;
    tick();
    exp_q.push_back(16'h0A00);
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL b2b_ready1: got %b exp 1", in_ready); end
    SrcData1 = 16'h0B00;
    tick();
    exp_q.push_back(16'h0B00);
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL b2b_ready2: got %b exp 0", in_ready); end
    SrcData1 = 16'h0C00;
    tick();
    tests++; if (in_ready !== 1'b0 || dbgState !== ST_TWO) begin failed++; $display("FAIL b2b_held_off: got ready %b state %0d exp 0/2", in_ready, dbgState); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_v = exp_q.pop_front();
      tests++; if (out_valid !== 1'b1 || out_A !== exp_v) begin failed++; $display("FAIL b2b_drain%0d: got valid %b A %h exp 1/%h", i, out_valid, out_A, exp_v); end
      tick();
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL b2b_ready_after%0d: got %b exp 1", i, in_ready); end
    end
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || out_A !== 16'h0B00) begin failed++; $display("FAIL b2b_empty: got valid %b A %h exp 0/0b00", out_valid, out_A); end
  endtask

  task automatic test_refresh();
    set_instr(4'd7, 16'h0001, 4'd3, 16'h0030, 4'd2, 16'h0007, 4'd7, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++; if (out_A !== 16'h0001) begin failed++; $display("FAIL ref_before: got %h exp 0001", out_A); end
    set_wb(1'b1, 4'd7, 16'h00FF);
    tick();
    set_wb(1'b0, 4'd0, 16'h0000);
    tests++; if (out_A !== 16'h00FF) begin failed++; $display("FAIL ref_A: got %h exp 00ff", out_A); end
    tests++; if (out_B !== 16'h0030 || out_Imm !== 16'h0007 || out_DstReg !== 4'd7) begin failed++; $display("FAIL ref_untouched: got %h/%h/%h exp 0030/0007/7", out_B, out_Imm, out_DstReg); end
    set_instr(4'd1, 16'h0011, 4'd7, 16'h0002, 4'd3, 16'h0000, 4'd4, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    set_wb(1'b1, 4'd7, 16'h0444);
    tick();
    set_wb(1'b0, 4'd0, 16'h0000);
    tests++; if (out_A !== 16'h0444) begin failed++; $display("FAIL ref_head_A: got %h exp 0444", out_A); end
    out_ready = 1'b1;
    tick();
    tests++; if (out_B !== 16'h0444 || out_A !== 16'h0011) begin failed++; $display("FAIL ref_tail: got B %h A %h exp 0444/0011", out_B, out_A); end
    set_wb(1'b1, 4'd7, 16'h0555);
    tick();
    set_wb(1'b0, 4'd0, 16'h0000);
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || out_B !== 16'h0555) begin failed++; $display("FAIL ref_dequeued: got valid %b B %h exp 0/0555", out_valid, out_B); end
  endtask

  task automatic test_flush();
    push(16'h0D00);
    push(16'h0E00);
    set_instr(4'd1, 16'h0F00, 4'd2, 16'h0000, 4'd1, 16'h0000, 4'd3, 1'b1);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failed++; $display("FAIL flush_two: got valid %b ready %b exp 0/1", out_valid, in_ready); end
    push(16'h1000);
    set_instr(4'd1, 16'h1100, 4'd2, 16'h0000, 4'd1, 16'h0000, 4'd3, 1'b1);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0 || dbgState !== ST_EMPTY) begin failed++; $display("FAIL flush_one_drop: got valid %b state %0d exp 0/0", out_valid, dbgState); end
    push(16'h1200);
    tests++; if (out_valid !== 1'b1 || out_A !== 16'h1200) begin failed++; $display("FAIL flush_after: got valid %b A %h exp 1/1200", out_valid, out_A); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    push(16'h2000);
    push(16'h2100);
    tests++; if (dbgState !== ST_TWO) begin failed++; $display("FAIL ar_filled: got %0d exp 2", dbgState); end
    #2 rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failed++; $display("FAIL ar_immediate: got valid %b ready %b exp 0/1", out_valid, in_ready); end
    tests++; if (out_A !== 16'h0000 || dbgState !== ST_EMPTY) begin failed++; $display("FAIL ar_cleared: got A %h state %0d exp 0000/0", out_A, dbgState); end
    tick();
    rst = 1'b1;
    push(16'h2200);
    tests++; if (out_valid !== 1'b1 || out_A !== 16'h2200) begin failed++; $display("FAIL ar_first_accept: got valid %b A %h exp 1/2200", out_valid, out_A); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_bypass();
    test_back_to_back();
    test_refresh();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
